// File: rtl/spi_cmd_frontend.sv
// SPI mode-0 slave front end: synchronises the MCU link into the clk domain and
// produces command/parameter byte strobes, frame counters and the MISO return path.
module spi_cmd_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ssel_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [7:0]  input_data,
  output logic        cmd_ready,
  output logic        param_ready,
  output logic [7:0]  cmd_data,
  output logic [7:0]  param_data,
  output logic [31:0] byte_cnt,
  output logic [2:0]  bit_cnt,
  output logic        startmessage,
  output logic        endmessage
);

  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] ssel_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   sck_hist_r;
  logic                   ssel_hist_r;

  logic sck_s, ssel_s, mosi_s;
  logic sck_rise_s, sck_fall_s, sel_start_s, sel_end_s;
  logic start_frame_s, end_frame_s;

  state_t state_r, state_s;

  logic [7:0]  rx_shift_r;
  logic [7:0]  tx_shift_r;
  logic        miso_r, miso_oe_r;
  logic        cmd_ready_r, param_ready_r;
  logic [7:0]  cmd_data_r, param_data_r;
  logic [31:0] byte_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic        startmessage_r, endmessage_r;

  // Input synchronisers, edge-history flops and post-reset fill tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      ssel_sync_r <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      fill_r      <= {SYNC_STAGES{1'b0}};
      sck_hist_r  <= 1'b0;
      ssel_hist_r <= 1'b1;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      ssel_sync_r <= {ssel_sync_r[SYNC_STAGES-2:0], ssel_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      sck_hist_r  <= sck_s;
      ssel_hist_r <= ssel_s;
    end
  end

  assign sck_s       = sck_sync_r[SYNC_STAGES-1];
  assign ssel_s      = ssel_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s  = sck_s & ~sck_hist_r;
  assign sck_fall_s  = ~sck_s & sck_hist_r;
  assign sel_start_s = ~ssel_s & ssel_hist_r;
  assign sel_end_s   = ssel_s & ~ssel_hist_r;

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_UNARMED;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame next-state: after reset, a genuinely deselected bus must be seen before
  // a falling ssel counts, so a frame caught mid-flight by reset is ignored.
  always_comb begin
    state_s       = state_r;
    start_frame_s = 1'b0;
    end_frame_s   = 1'b0;
    case (state_r)
      ST_UNARMED: begin
        if (fill_r[SYNC_STAGES-1] && ssel_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_UNARMED;
        end
      end
      ST_IDLE: begin
        if (sel_start_s) begin
          state_s       = ST_ACTIVE;
          start_frame_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (sel_end_s) begin
          state_s     = ST_IDLE;
          end_frame_s = 1'b1;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      default: begin
        state_s = ST_UNARMED;
      end
    endcase
  end

  // Shift registers, counters, byte capture and one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift_r     <= 8'h00;
      tx_shift_r     <= 8'h00;
      miso_r         <= 1'b0;
      miso_oe_r      <= 1'b0;
      cmd_ready_r    <= 1'b0;
      param_ready_r  <= 1'b0;
      cmd_data_r     <= 8'h00;
      param_data_r   <= 8'h00;
      byte_cnt_r     <= 32'd0;
      bit_cnt_r      <= 3'd0;
      startmessage_r <= 1'b0;
      endmessage_r   <= 1'b0;
    end else begin
      cmd_ready_r    <= 1'b0;
      param_ready_r  <= 1'b0;
      startmessage_r <= 1'b0;
      endmessage_r   <= 1'b0;
      if (sel_end_s) begin
        // Deselect beats a coincident SCK edge; any partial byte is dropped.
        rx_shift_r   <= 8'h00;
        tx_shift_r   <= 8'h00;
        miso_r       <= 1'b0;
        miso_oe_r    <= 1'b0;
        byte_cnt_r   <= 32'd0;
        bit_cnt_r    <= 3'd0;
        endmessage_r <= end_frame_s;
      end else if (start_frame_s) begin
        rx_shift_r     <= 8'h00;
        tx_shift_r     <= 8'h00;
        miso_r         <= 1'b0;
        miso_oe_r      <= 1'b1;
        byte_cnt_r     <= 32'd0;
        bit_cnt_r      <= 3'd0;
        startmessage_r <= 1'b1;
      end else if (state_r == ST_ACTIVE) begin
        if (sck_rise_s) begin
          rx_shift_r <= {rx_shift_r[6:0], mosi_s};
          bit_cnt_r  <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            if (byte_cnt_r != 32'hFFFF_FFFF) begin
              byte_cnt_r <= byte_cnt_r + 32'd1;
            end
            if (byte_cnt_r == 32'd0) begin
              cmd_data_r  <= {rx_shift_r[6:0], mosi_s};
              cmd_ready_r <= 1'b1;
            end else begin
              param_data_r  <= {rx_shift_r[6:0], mosi_s};
              param_ready_r <= 1'b1;
            end
            tx_shift_r <= input_data;
          end
        end else if (sck_fall_s) begin
          miso_r     <= tx_shift_r[7];
          tx_shift_r <= {tx_shift_r[6:0], 1'b0};
        end
      end
    end
  end

  assign miso         = miso_r;
  assign miso_oe      = miso_oe_r;
  assign cmd_ready    = cmd_ready_r;
  assign param_ready  = param_ready_r;
  assign cmd_data     = cmd_data_r;
  assign param_data   = param_data_r;
  assign byte_cnt     = byte_cnt_r;
  assign bit_cnt      = bit_cnt_r;
  assign startmessage = startmessage_r;
  assign endmessage   = endmessage_r;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// Directed bench for spi_cmd_frontend: expected strobe events are queued as stimulus
// is issued and a negedge monitor pops and compares them against the DUT outputs.
module tb_spi_cmd_frontend;

  localparam int SS = 2;
  localparam int HP_NORM = 5;
  localparam int HP_MIN = SS + 2;

  localparam int K_CMD = 0;
  localparam int K_PARAM = 1;
  localparam int K_START = 2;
  localparam int K_END = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ssel_n = 1'b1;
  logic        mosi = 1'b0;
  logic [7:0]  input_data = 8'h00;
  logic        miso, miso_oe, cmd_ready, param_ready, startmessage, endmessage;
  logic [7:0]  cmd_data, param_data;
  logic [31:0] byte_cnt;
  logic [2:0]  bit_cnt;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    logic [31:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  spi_cmd_frontend #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ssel_n(ssel_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .input_data(input_data),
    .cmd_ready(cmd_ready), .param_ready(param_ready),
    .cmd_data(cmd_data), .param_data(param_data),
    .byte_cnt(byte_cnt), .bit_cnt(bit_cnt),
    .startmessage(startmessage), .endmessage(endmessage)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int k, input logic [7:0] d, input logic [31:0] c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MCU side of mode 0: drive MOSI while SCK low, sample MISO at the rising edge.
  task automatic spi_bits(input logic [7:0] b, input int n, input int hp, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      wclk(hp);
      sck = 1'b1;
      got = {got[6:0], miso};
      wclk(hp);
      sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    ssel_n = 1'b0;
    wclk(6);
  endtask

  task automatic frame_end();
    wclk(6);
    ssel_n = 1'b1;
    wclk(8);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " miso"}, {31'd0, miso}, 32'd0);
    check({tag, " miso_oe"}, {31'd0, miso_oe}, 32'd0);
    check({tag, " cmd_data"}, {24'd0, cmd_data}, 32'd0);
    check({tag, " param_data"}, {24'd0, param_data}, 32'd0);
    check({tag, " byte_cnt"}, byte_cnt, 32'd0);
    check({tag, " bit_cnt"}, {29'd0, bit_cnt}, 32'd0);
    check({tag, " strobes"}, {28'd0, cmd_ready, param_ready, startmessage, endmessage}, 32'd0);
  endtask

  // Scoreboard monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    int  kind;
    ev_t e;
    if (cmd_ready | param_ready | startmessage | endmessage) begin
      check("single strobe", $countones({cmd_ready, param_ready, startmessage, endmessage}), 32'd1);
      kind = cmd_ready ? K_CMD : (param_ready ? K_PARAM : (startmessage ? K_START : K_END));
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected event: got kind %0d expected none", kind);
      end else begin
        e = exp_q.pop_front();
        check("event kind", kind, e.kind);
        if (e.kind == K_CMD) begin
          check("cmd_data", {24'd0, cmd_data}, {24'd0, e.data});
          check("cmd byte_cnt", byte_cnt, e.cnt);
        end else if (e.kind == K_PARAM) begin
          check("param_data", {24'd0, param_data}, {24'd0, e.data});
          check("param byte_cnt", byte_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] d;

    wclk(4);
    rst = 1'b0;
    check_reset_state("reset");
    wclk(4);

    // Four-byte frame with MISO return data
    push_ev(K_START, 8'h00, 32'd0);
    push_ev(K_CMD, 8'h10, 32'd1);
    push_ev(K_PARAM, 8'h12, 32'd2);
    push_ev(K_PARAM, 8'h34, 32'd3);
    push_ev(K_PARAM, 8'h56, 32'd4);
    push_ev(K_END, 8'h00, 32'd0);
    frame_begin();
    check("miso_oe selected", {31'd0, miso_oe}, 32'd1);
    input_data = 8'hA5;
    spi_bits(8'h10, 8, HP_NORM, got);
    check("miso byte0", {24'd0, got}, 32'h00);
    input_data = 8'h3C;
    spi_bits(8'h12, 8, HP_NORM, got);
    check("miso byte1", {24'd0, got}, 32'hA5);
    input_data = 8'h00;
    spi_bits(8'h34, 8, HP_NORM, got);
    check("miso byte2", {24'd0, got}, 32'h3C);
    spi_bits(8'h56, 8, HP_NORM, got);
    check("frame byte_cnt", byte_cnt, 32'd4);
    frame_end();
    check("miso_oe deselected", {31'd0, miso_oe}, 32'd0);
    check("cmd_data held", {24'd0, cmd_data}, 32'h10);
    check("param_data held", {24'd0, param_data}, 32'h56);

    // Abort after 5 bits of the second byte
    push_ev(K_START, 8'h00, 32'd0);
    push_ev(K_CMD, 8'hAB, 32'd1);
    push_ev(K_END, 8'h00, 32'd0);
    frame_begin();
    spi_bits(8'hAB, 8, HP_NORM, got);
    spi_bits(8'hCD, 5, HP_NORM, got);
    check("partial bit_cnt", {29'd0, bit_cnt}, 32'd5);
    frame_end();
    check("abort bit_cnt", {29'd0, bit_cnt}, 32'd0);
    check("abort byte_cnt", byte_cnt, 32'd0);
    check("abort cmd_data", {24'd0, cmd_data}, 32'hAB);
    check("abort param_data", {24'd0, param_data}, 32'h56);
    push_ev(K_START, 8'h00, 32'd0);
    push_ev(K_CMD, 8'hF0, 32'd1);
    push_ev(K_END, 8'h00, 32'd0);
    frame_begin();
    spi_bits(8'hF0, 8, HP_NORM, got);
    frame_end();
    check("next cmd_data", {24'd0, cmd_data}, 32'hF0);

    // Reset pulse at bit 3 of byte 2; rest of that frame must be ignored
    push_ev(K_START, 8'h00, 32'd0);
    push_ev(K_CMD, 8'h77, 32'd1);
    frame_begin();
    spi_bits(8'h77, 8, HP_NORM, got);
    spi_bits(8'h5A, 3, HP_NORM, got);
    rst = 1'b1;
    wclk(1);
    rst = 1'b0;
    check_reset_state("midrst");
    check("queue after rst", exp_q.size(), 32'd0);
    spi_bits(8'hFF, 5, HP_NORM, got);
    spi_bits(8'h99, 8, HP_NORM, got);
    check("ignored byte_cnt", byte_cnt, 32'd0);
    check("ignored miso_oe", {31'd0, miso_oe}, 32'd0);
    frame_end();
    push_ev(K_START, 8'h00, 32'd0);
    push_ev(K_CMD, 8'h20, 32'd1);
    push_ev(K_PARAM, 8'h11, 32'd2);
    push_ev(K_END, 8'h00, 32'd0);
    frame_begin();
    spi_bits(8'h20, 8, HP_NORM, got);
    spi_bits(8'h11, 8, HP_NORM, got);
    frame_end();
    check("post-rst cmd_data", {24'd0, cmd_data}, 32'h20);
    check("post-rst param_data", {24'd0, param_data}, 32'h11);

    // Idle SCK toggling while deselected
    for (int i = 0; i < 20; i++) begin
      sck = ~sck;
      wclk(3);
    end
    sck = 1'b0;
    wclk(4);
    check("idle byte_cnt", byte_cnt, 32'd0);
    check("idle bit_cnt", {29'd0, bit_cnt}, 32'd0);
    check("idle miso_oe", {31'd0, miso_oe}, 32'd0);

    // Sixteen bytes at the fastest legal SCK
    push_ev(K_START, 8'h00, 32'd0);
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 37 + 5);
      push_ev((i == 0) ? K_CMD : K_PARAM, d, 32'(i + 1));
    end
    push_ev(K_END, 8'h00, 32'd0);
    frame_begin();
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 37 + 5);
      spi_bits(d, 8, HP_MIN, got);
    end
    wclk(4);
    check("fast byte_cnt", byte_cnt, 32'd16);
    frame_end();
    check("fast byte_cnt cleared", byte_cnt, 32'd0);

    check("queue drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
